// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
//   Upstream control stage for an N:1 channel mux. Steps the mux select from
//   0 to NUM_CH-1, holding each value DWELL cycles so the mux path settles,
//   and captures mux_out on the last cycle of each dwell. A completed frame
//   rebuilds the mux data input: sample_data[k] = mux input k.
//   One frame per start pulse, or back-to-back frames while continuous is high.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   start         begin one frame (honoured only in IDLE)
//   continuous    level, looked at only in DONE: 1 = begin the next frame at once
//   mux_out       output of the mux under control
//   select        registered mux select
//   sample_data   last completed frame (bit k captured with select==k)
//   sample_valid  one-cycle pulse: sample_data was just written
//   busy          high in SCAN and DONE
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; select parked at 0
// SCAN  | sweeping select, dwell_cnt counts up within each channel
// DONE  | one cycle; frame published, sample_valid high, select at last
module mux_scan_sequencer #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2,
  parameter int DWELL  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic              mux_out,
  output logic [SEL_W-1:0]  select,
  output logic [NUM_CH-1:0] sample_data,
  output logic              sample_valid,
  output logic              busy
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  dwell_cnt, dwell_cnt_nx;
  logic [SEL_W-1:0]  select_nx;
  logic [NUM_CH-1:0] shadow, shadow_nx;
  logic [NUM_CH-1:0] sample_data_nx;
  logic              sample_valid_nx;
  logic              busy_nx;

  always_comb begin
    state_nx       = state;
    dwell_cnt_nx   = dwell_cnt;
    select_nx      = select;
    shadow_nx      = shadow;
    sample_data_nx = sample_data;

    case (state)
      IDLE: begin
        select_nx    = '0;
        dwell_cnt_nx = '0;
        if (start) begin
          state_nx  = SCAN;
          shadow_nx = '0;
        end
      end

      SCAN: begin
        if (dwell_cnt == CNT_LAST) begin
          shadow_nx[select] = mux_out;
          dwell_cnt_nx      = '0;
          if (select == SEL_LAST) begin
            // Last channel goes straight into the published word; the
            // shadow only has to hold the earlier channels.
            sample_data_nx = {mux_out, shadow[NUM_CH-2:0]};
            state_nx       = DONE;
          end else begin
            select_nx = select + 1'b1;
          end
        end else begin
          dwell_cnt_nx = dwell_cnt + 1'b1;
        end
      end

      DONE: begin
        dwell_cnt_nx = '0;
        select_nx    = '0;
        if (continuous) begin
          state_nx  = SCAN;
          shadow_nx = '0;
        end else begin
          state_nx = IDLE;
        end
      end

      default: begin
        state_nx     = IDLE;
        select_nx    = '0;
        dwell_cnt_nx = '0;
      end
    endcase

    // Registered status outputs follow the state being entered.
    sample_valid_nx = (state_nx == DONE);
    busy_nx         = (state_nx != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      dwell_cnt    <= '0;
      select       <= '0;
      shadow       <= '0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nx;
      dwell_cnt    <= dwell_cnt_nx;
      select       <= select_nx;
      shadow       <= shadow_nx;
      sample_data  <= sample_data_nx;
      sample_valid <= sample_valid_nx;
      busy         <= busy_nx;
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: one instance with DWELL=4, one with DWELL=1.
// Each mux is modelled as mux_out = in[select]. Expected frames are queued
// when start is issued; monitors pop them when sample_valid is seen.
module tb_mux_scan_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start4, cont4, mux_out4, sv4, busy4;
  logic [3:0] in4, sd4;
  logic [1:0] sel4;
  logic       start1, cont1, mux_out1, sv1, busy1;
  logic [3:0] in1, sd1;
  logic [1:0] sel1;

  assign mux_out4 = in4[sel4];
  assign mux_out1 = in1[sel1];

  mux_scan_sequencer #(.NUM_CH(4), .SEL_W(2), .DWELL(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .continuous(cont4),
    .mux_out(mux_out4), .select(sel4), .sample_data(sd4),
    .sample_valid(sv4), .busy(busy4)
  );

  mux_scan_sequencer #(.NUM_CH(4), .SEL_W(2), .DWELL(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .continuous(cont1),
    .mux_out(mux_out1), .select(sel1), .sample_data(sd1),
    .sample_valid(sv1), .busy(busy1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0]  data;
    logic [31:0] cyc;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: actual %0h required %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sv4) begin
      check("valid4_expected", 32'(q4.size() != 0), 32'd1);
      if (q4.size() != 0) begin
        e = q4.pop_front();
        check("data4", 32'(sd4), 32'(e.data));
        check("valid4_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (sv1) begin
      check("valid1_expected", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check("data1", 32'(sd1), 32'(e.data));
        check("valid1_cycle", cyc, e.cyc);
      end
    end
  end

  // Single frame on the DWELL=4 instance. Cycle k after the start cycle
  // shows select (k-1)/4 for k=1..16, DONE at k=17, IDLE at k=18.
  task automatic frame4(input logic [3:0] pat, input bit repulse);
    int c;
    @(posedge clk); #1;
    in4 = pat; start4 = 1'b1; c = cyc;
    q4.push_back('{data: pat, cyc: 32'(c + 17)});
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      check("select4", 32'(sel4), (k <= 16) ? 32'((k - 1) / 4) : ((k == 17) ? 32'd3 : 32'd0));
      check("busy4", 32'(busy4), 32'(k <= 17));
      if (k == 18) check("hold4", 32'(sd4), 32'(pat));
      if (repulse) start4 = (k == 4 || k == 15);
    end
    start4 = 1'b0;
  endtask

  // Continuous frames; data changed during DONE, continuous dropped in
  // cycle 3 of the second frame.
  task automatic cont_frames();
    int c;
    @(posedge clk); #1;
    in4 = 4'b1001; cont4 = 1'b1; start4 = 1'b1; c = cyc;
    q4.push_back('{data: 4'b1001, cyc: 32'(c + 17)});
    q4.push_back('{data: 4'b0110, cyc: 32'(c + 34)});
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int k = 1; k <= 54; k++) begin
      @(negedge clk);
      if (k == 17) begin
        check("cont_select_done1", 32'(sel4), 32'd3);
        in4 = 4'b0110;
      end
      if (k == 18) begin
        check("cont_select_nogap", 32'(sel4), 32'd0);
        check("cont_busy_nogap", 32'(busy4), 32'd1);
      end
      if (k == 20) cont4 = 1'b0;
      if (k == 34) check("cont_select_done2", 32'(sel4), 32'd3);
      if (k == 35 || k == 54) check("cont_busy_after", 32'(busy4), 32'd0);
    end
  endtask

  task automatic reset_mid_frame();
    @(posedge clk); #1;
    in4 = 4'b1111; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 8) check("rst_select_before", 32'(sel4), 32'd1);
      if (k == 9) reset = 1'b1;
      if (k == 10) begin
        reset = 1'b0;
        check("rst_select", 32'(sel4), 32'd0);
        check("rst_busy", 32'(busy4), 32'd0);
        check("rst_data", 32'(sd4), 32'd0);
        check("rst_valid", 32'(sv4), 32'd0);
      end
      if (k == 20) check("rst_stays_idle", 32'(busy4), 32'd0);
    end
  endtask

  task automatic frame1(input logic [3:0] pat);
    int c;
    @(posedge clk); #1;
    in1 = pat; start1 = 1'b1; c = cyc;
    q1.push_back('{data: pat, cyc: 32'(c + 5)});
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("select1", 32'(sel1), (k <= 4) ? 32'(k - 1) : ((k == 5) ? 32'd3 : 32'd0));
      check("busy1", 32'(busy1), 32'(k <= 5));
    end
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
  endtask

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached, actual running required finished");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start4 = 1'b0; cont4 = 1'b0; in4 = 4'b0000;
    start1 = 1'b0; cont1 = 1'b0; in1 = 4'b0000;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_select4", 32'(sel4), 32'd0);
    check("reset_busy4", 32'(busy4), 32'd0);
    check("reset_data4", 32'(sd4), 32'd0);
    check("reset_valid4", 32'(sv4), 32'd0);
    check("reset_select1", 32'(sel1), 32'd0);
    check("reset_busy1", 32'(busy1), 32'd0);
    check("reset_data1", 32'(sd1), 32'd0);
    check("reset_valid1", 32'(sv1), 32'd0);

    frame4(4'b1001, 1'b0);
    frame4(4'b1100, 1'b1);
    cont_frames();
    reset_mid_frame();
    frame4(4'b1010, 1'b0);
    frame1(4'b0011);

    repeat (4) @(negedge clk);
    check("pending4", q4.size(), 32'd0);
    check("pending1", q1.size(), 32'd0);
    summary();
    $finish;
  end

endmodule
